// File: rtl/lab4_pkg.sv
// Shared constants and encodings for the lab4 ROM arbiter and its ROM.
package lab4_pkg;

  localparam int ADDR_W = 4;  // 16 ROM entries
  localparam int DATA_W = 5;  // ROM word width

  // Sequencer state: IDLE arbitrates, READ captures the ROM word.
  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  // Requester identity, used both for the read owner and the last winner.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/lab4ROM.sv
// 16x5 combinational lookup ROM. Word i holds (3*i) modulo 32.
module lab4ROM
  import lab4_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Pure table lookup; the contents are constants, so there is nothing to reset.
  always_comb begin
    // NOTE: a default assigned before the case keeps every path driven, so no latch is inferred.
    data = '0;
    case (addr)
      4'd0:  data = 5'd0;
      4'd1:  data = 5'd3;
      4'd2:  data = 5'd6;
      4'd3:  data = 5'd9;
      4'd4:  data = 5'd12;
      4'd5:  data = 5'd15;
      4'd6:  data = 5'd18;
      4'd7:  data = 5'd21;
      4'd8:  data = 5'd24;
      4'd9:  data = 5'd27;
      4'd10: data = 5'd30;
      4'd11: data = 5'd1;
      4'd12: data = 5'd4;
      4'd13: data = 5'd7;
      4'd14: data = 5'd10;
      4'd15: data = 5'd13;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lab4_rom_arbiter.sv
// Two-port round-robin arbiter and read sequencer for the shared lab4ROM.
// One word per two cycles: IDLE grants and latches the address, READ
// captures the ROM word and pulses the owner's valid.
// Optional feature: define LAB4_ARB_CHECKSUM_EN to add the running XOR
// checksum port over every returned word.
module lab4_rom_arbiter
  import lab4_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              reqA,
  input  logic [ADDR_W-1:0] addrA,
  input  logic              reqB,
  input  logic [ADDR_W-1:0] addrB,
  output logic              gntA,
  output logic              gntB,
  output logic [DATA_W-1:0] rdata,
  output logic              validA,
  output logic              validB,
  output logic              busy
`ifdef LAB4_ARB_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  state_t            state_q, state_d;
  req_id_t           owner_q, last_winner_q, winner;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [DATA_W-1:0] rom_data;
  logic              grant_a, grant_b, capture;

  lab4ROM u_rom (
    .addr (rom_addr_q),
    .data (rom_data)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state, arbitration winner and per-cycle strobes.
  always_comb begin
    state_d = state_q;
    winner  = REQ_A;
    grant_a = 1'b0;
    grant_b = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time goes first.
        if (reqA && reqB)  winner = (last_winner_q == REQ_A) ? REQ_B : REQ_A;
        else if (reqB)     winner = REQ_B;
        else               winner = REQ_A;
        if (reqA || reqB) begin
          state_d = READ;
          grant_a = (winner == REQ_A);
          grant_b = (winner == REQ_B);
        end
      end
      READ: begin
        // Requests are ignored here; the ROM output is captured this edge.
        state_d = IDLE;
        capture = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant/valid pulses, address latch, read owner, and word capture.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      gntA          <= 1'b0;
      gntB          <= 1'b0;
      validA        <= 1'b0;
      validB        <= 1'b0;
      rdata         <= '0;
      rom_addr_q    <= '0;
      owner_q       <= REQ_A;
      last_winner_q <= REQ_B;
    end else begin
      gntA   <= grant_a;
      gntB   <= grant_b;
      validA <= capture && (owner_q == REQ_A);
      validB <= capture && (owner_q == REQ_B);
      if (grant_a || grant_b) begin
        rom_addr_q <= grant_a ? addrA : addrB;
        owner_q    <= winner;
      end
      if (capture) begin
        rdata         <= rom_data;
        last_winner_q <= owner_q;
      end
    end
  end

  assign busy = (state_q == READ);

`ifdef LAB4_ARB_CHECKSUM_EN
  // Running XOR of every returned word, updated alongside the valid pulse.
  always_ff @(posedge CLK) begin
    if (!RSTn)        checksum <= '0;
    else if (capture) checksum <= checksum ^ rom_data;
  end
`endif

endmodule

// File: tb/tb_lab4_rom_arbiter.sv
// Directed self-checking bench for lab4_rom_arbiter.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_lab4_rom_arbiter;
  import lab4_pkg::*;

  logic              CLK = 1'b0;
  logic              RSTn;
  logic              reqA, reqB;
  logic [ADDR_W-1:0] addrA, addrB;
  logic              gntA, gntB, validA, validB, busy;
  logic [DATA_W-1:0] rdata;
`ifdef LAB4_ARB_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  int checks   = 0;
  int failures = 0;

  // Expected contention pattern, both requests held high, addrA=2, addrB=0.
  int exp_ga [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
  int exp_va [8] = '{0, 1, 0, 0, 0, 1, 0, 0};
  int exp_gb [8] = '{0, 0, 1, 0, 0, 0, 1, 0};
  int exp_vb [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  int exp_rd [8] = '{0, 6, 6, 0, 0, 6, 6, 0};

  lab4_rom_arbiter dut (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .reqA   (reqA),
    .addrA  (addrA),
    .reqB   (reqB),
    .addrB  (addrB),
    .gntA   (gntA),
    .gntB   (gntB),
    .rdata  (rdata),
    .validA (validA),
    .validB (validB),
    .busy   (busy)
`ifdef LAB4_ARB_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RSTn = 1'b0; reqA = 1'b0; reqB = 1'b0; addrA = '0; addrB = '0;

    // Reset held two cycles.
    tick(); tick();
    check("rst_gntA", gntA, 0);
    check("rst_gntB", gntB, 0);
    check("rst_validA", validA, 0);
    check("rst_validB", validB, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 0);
`ifdef LAB4_ARB_CHECKSUM_EN
    check("rst_checksum", checksum, 0);
`endif
    RSTn = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // Single A read of address 2; address changes after the grant.
    reqA = 1'b1; addrA = 4'd2;
    tick();
    check("a_gntA", gntA, 1);
    check("a_gntB", gntB, 0);
    check("a_busy", busy, 1);
    check("a_validA_early", validA, 0);
    reqA = 1'b0; addrA = 4'd15;
    tick();
    check("a_validA", validA, 1);
    check("a_validB", validB, 0);
    check("a_rdata", rdata, 5'b00110);
    check("a_gnt_low", gntA, 0);
    check("a_busy_low", busy, 0);
`ifdef LAB4_ARB_CHECKSUM_EN
    check("cks_after_2", checksum, 5'b00110);
`endif
    tick();
    check("a_valid_pulse", validA, 0);
    check("a_rdata_hold", rdata, 5'b00110);

    // Single B read of address 0.
    reqB = 1'b1; addrB = 4'd0;
    tick();
    check("b_gntB", gntB, 1);
    check("b_gntA", gntA, 0);
    reqB = 1'b0;
    tick();
    check("b_validB", validB, 1);
    check("b_validA", validA, 0);
    check("b_rdata", rdata, 5'b00000);
`ifdef LAB4_ARB_CHECKSUM_EN
    check("cks_after_0", checksum, 5'b00110);
`endif
    tick();
    check("b_idle_busy", busy, 0);

    // Contention: both held high, last winner B, so A, B, A, B.
    reqA = 1'b1; addrA = 4'd2; reqB = 1'b1; addrB = 4'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("cont%0d_gntA", i), gntA, exp_ga[i]);
      check($sformatf("cont%0d_gntB", i), gntB, exp_gb[i]);
      check($sformatf("cont%0d_validA", i), validA, exp_va[i]);
      check($sformatf("cont%0d_validB", i), validB, exp_vb[i]);
      check($sformatf("cont%0d_rdata", i), rdata, exp_rd[i]);
    end
    reqA = 1'b0; reqB = 1'b0;
    tick();
    check("cont_drain_busy", busy, 0);

    // Reset mid-read: first load rdata with a nonzero word.
    reqA = 1'b1; addrA = 4'd2;
    tick();
    check("mr_gntA", gntA, 1);
    reqA = 1'b0;
    tick();
    check("mr_rdata_pre", rdata, 5'b00110);
    reqA = 1'b1;
    tick();
    check("mr_gntA2", gntA, 1);
    check("mr_busy", busy, 1);
    RSTn = 1'b0; reqA = 1'b0;
    tick();
    check("mr_validA", validA, 0);
    check("mr_rdata", rdata, 0);
    check("mr_busy_low", busy, 0);
    check("mr_gntA_low", gntA, 0);
`ifdef LAB4_ARB_CHECKSUM_EN
    check("mr_checksum", checksum, 0);
`endif
    RSTn = 1'b1;
    tick();
    check("mr_idle_busy", busy, 0);
    check("mr_no_valid", validA, 0);

    // First tie after reset goes to A.
    reqA = 1'b1; addrA = 4'd2; reqB = 1'b1; addrB = 4'd0;
    tick();
    check("tie_gntA", gntA, 1);
    check("tie_gntB", gntB, 0);
    reqA = 1'b0; reqB = 1'b0;
    tick();
    check("tie_validA", validA, 1);
    check("tie_rdata", rdata, 5'b00110);
`ifdef LAB4_ARB_CHECKSUM_EN
    check("cks_r1", checksum, 5'b00110);
    tick();
    reqB = 1'b1; addrB = 4'd0;
    tick();
    reqB = 1'b0;
    tick();
    check("cks_r2", checksum, 5'b00110);
    tick();
    reqA = 1'b1; addrA = 4'd2;
    tick();
    reqA = 1'b0;
    tick();
    check("cks_r3", checksum, 5'b00000);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
